// File: rtl/sram_req_scheduler.sv
// Four-port SRAM request scheduler: two write ports and two read ports arbitrated
// round-robin with a starvation override, a registered SRAM command stage, and a
// tag pipeline that steers returning read data to the requesting read-data FIFO.
`timescale 1ns/1ps

module sram_req_scheduler #(
    parameter int unsigned READ_LATENCY = 3,
    parameter int unsigned MAX_WAIT     = 15
) (
    input  logic        sram_clock,
    input  logic        reset,
    input  logic [3:0]  req_valid,
    output logic [3:0]  req_pop,
    input  logic [53:0] w0_cmd,
    input  logic [53:0] w1_cmd,
    input  logic [17:0] r0_addr,
    input  logic [17:0] r1_addr,
    input  logic        r0_full,
    input  logic        r1_full,
    input  logic        sram_ready,
    output logic        sram_addr_valid,
    output logic [17:0] sram_addr,
    output logic [31:0] sram_data_in,
    output logic [3:0]  sram_write_mask,
    input  logic        sram_data_out_valid,
    output logic        r0_data_wr,
    output logic        r1_data_wr,
    output logic        tag_error
);

    localparam int unsigned CW = $clog2(MAX_WAIT + 1);
    localparam int unsigned DW = $clog2(READ_LATENCY + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_WAIT);

    typedef enum logic [1:0] {StIdle, StIssue, StHold} state_t;

    state_t              state_q;
    logic [1:0]          ptr_q;
    logic [CW-1:0]       wait_cnt_q [4];
    logic                cmd_read_q;
    logic                cmd_port_q;
    logic [READ_LATENCY-1:0] tag_valid_q;
    logic [READ_LATENCY-1:0] tag_port_q;
    logic [DW-1:0]       drain_q;

    logic [3:0]  eligible;
    logic [3:0]  starved;
    logic [3:0]  grant;
    logic [1:0]  grant_idx;
    logic        can_grant;
    logic [1:0]  idx;
    logic [17:0] nxt_addr;
    logic [31:0] nxt_data;
    logic [3:0]  nxt_mask;
    logic        tag_out_valid;
    logic        tag_out_port;
    logic        push_tag;
    logic        tag_err;

    // Arbitration: starved ports (lowest index) beat the round-robin pointer.
    always_comb begin
        eligible  = req_valid & {~r1_full, ~r0_full, 2'b11};
        can_grant = (state_q == StIdle) || sram_ready;
        starved   = '0;
        grant     = '0;
        grant_idx = '0;
        idx       = '0;
        for (int i = 0; i < 4; i++) begin
            starved[i] = eligible[i] && (wait_cnt_q[i] == MAX_CNT);
        end
        if (can_grant && !reset) begin
            if (starved != 4'b0000) begin
                // Descending scan so the lowest index is assigned last and wins.
                for (int i = 3; i >= 0; i--) begin
                    idx = 2'(i);
                    if (starved[idx]) begin
                        grant     = 4'b0001 << idx;
                        grant_idx = idx;
                    end
                end
            end else begin
                for (int i = 3; i >= 0; i--) begin
                    idx = ptr_q + 2'(i);
                    if (eligible[idx]) begin
                        grant     = 4'b0001 << idx;
                        grant_idx = idx;
                    end
                end
            end
        end
        req_pop = grant;
    end

    // Command mux for the granted port; reads carry no data and no mask.
    always_comb begin
        nxt_addr = '0;
        nxt_data = '0;
        nxt_mask = '0;
        case (grant_idx)
            2'd0: begin
                nxt_addr = w0_cmd[49:32];
                nxt_data = w0_cmd[31:0];
                nxt_mask = w0_cmd[53:50];
            end
            2'd1: begin
                nxt_addr = w1_cmd[49:32];
                nxt_data = w1_cmd[31:0];
                nxt_mask = w1_cmd[53:50];
            end
            2'd2:    nxt_addr = r0_addr;
            default: nxt_addr = r1_addr;
        endcase
    end

    // Issue FSM with the registered SRAM command stage and round-robin pointer.
    always_ff @(posedge sram_clock) begin
        if (reset) begin
            state_q         <= StIdle;
            ptr_q           <= '0;
            sram_addr_valid <= 1'b0;
            sram_addr       <= '0;
            sram_data_in    <= '0;
            sram_write_mask <= '0;
            cmd_read_q      <= 1'b0;
            cmd_port_q      <= 1'b0;
        end else begin
            if (can_grant && grant != 4'b0000) begin
                state_q         <= StIssue;
                ptr_q           <= grant_idx + 2'd1;
                sram_addr_valid <= 1'b1;
                sram_addr       <= nxt_addr;
                sram_data_in    <= nxt_data;
                sram_write_mask <= nxt_mask;
                cmd_read_q      <= grant_idx[1];
                cmd_port_q      <= grant_idx[0];
            end else begin
                case (state_q)
                    StIssue, StHold: begin
                        if (sram_ready) begin
                            state_q         <= StIdle;
                            sram_addr_valid <= 1'b0;
                        end else begin
                            state_q <= StHold;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    // Per-port wait counters: count eligible-but-not-granted cycles, saturating.
    always_ff @(posedge sram_clock) begin
        for (int i = 0; i < 4; i++) begin
            if (reset || grant[i]) begin
                wait_cnt_q[i] <= '0;
            end else if (eligible[i] && wait_cnt_q[i] != MAX_CNT) begin
                wait_cnt_q[i] <= wait_cnt_q[i] + 1'b1;
            end
        end
    end

    // Read-return routing and error detection on the tag emerging from the pipe.
    always_comb begin
        push_tag      = sram_addr_valid && sram_ready && cmd_read_q;
        tag_out_valid = tag_valid_q[READ_LATENCY-1];
        tag_out_port  = tag_port_q[READ_LATENCY-1];
        r0_data_wr    = !reset && sram_data_out_valid && tag_out_valid && !tag_out_port;
        r1_data_wr    = !reset && sram_data_out_valid && tag_out_valid && tag_out_port;
        // Untagged data right after reset belongs to commands the reset discarded.
        tag_err = (sram_data_out_valid && !tag_out_valid && drain_q == '0)
               || (tag_out_valid && !sram_data_out_valid);
    end

    // Tag shift register, post-reset drain window and sticky error flag.
    always_ff @(posedge sram_clock) begin
        if (reset) begin
            tag_valid_q <= '0;
            tag_port_q  <= '0;
            drain_q     <= DW'(READ_LATENCY);
            tag_error   <= 1'b0;
        end else begin
            for (int i = READ_LATENCY - 1; i > 0; i--) begin
                tag_valid_q[i] <= tag_valid_q[i-1];
                tag_port_q[i]  <= tag_port_q[i-1];
            end
            tag_valid_q[0] <= push_tag;
            tag_port_q[0]  <= cmd_port_q;
            if (drain_q != '0) begin
                drain_q <= drain_q - 1'b1;
            end
            if (tag_err) begin
                tag_error <= 1'b1;
            end
        end
    end

endmodule

// File: doc/sram_req_scheduler.md
SRAM_REQ_SCHEDULER -- requirements
Module: sram_req_scheduler

Interface
REQ-001 SHALL have parameter READ_LATENCY, default 3: cycles from SRAM command acceptance to sram_data_out_valid for a read.
REQ-002 SHALL have parameter MAX_WAIT, default 15: starvation threshold in cycles; counter width is clog2(MAX_WAIT+1).
REQ-003 SHALL have port sram_clock, input, 1: the only clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high.
REQ-005 SHALL have port req_valid, input, 4: pending request per port; bit0 W0, bit1 W1, bit2 R0, bit3 R1.
REQ-006 SHALL have port req_pop, output, 4: one-hot grant; pops the granted port's source FIFO in the same cycle.
REQ-007 SHALL have ports w0_cmd and w1_cmd, input, 54 each: {mask[53:50], addr[49:32], data[31:0]}.
REQ-008 SHALL have ports r0_addr and r1_addr, input, 18 each: read addresses.
REQ-009 SHALL have ports r0_full and r1_full, input, 1 each: read-data FIFO programmable-full.
REQ-010 SHALL have port sram_ready, input, 1: SRAM accepts the presented command this cycle.
REQ-011 SHALL have output ports sram_addr_valid (1), sram_addr (18), sram_data_in (32) and sram_write_mask (4); all registered.
REQ-012 SHALL have port sram_data_out_valid, input, 1: read data returning.
REQ-013 SHALL have ports r0_data_wr and r1_data_wr, output, 1 each: read-data FIFO write enables.
REQ-014 SHALL have port tag_error, output, 1: sticky; set on a read-return mismatch.

Function
REQ-015 SHALL treat W0 and W1 as eligible when their req_valid bit is 1; R0 and R1 as eligible when req_valid is 1 and the matching rN_full is 0.
REQ-016 SHALL implement FSM IDLE / ISSUE / HOLD: IDLE = output register empty; ISSUE = command presented; HOLD = command presented with sram_ready=0.
REQ-017 SHALL grant at most one port per cycle, and only when in IDLE, or in ISSUE/HOLD with sram_ready=1.
REQ-018 SHALL assert req_pop combinationally in the grant cycle and present the command on sram_* exactly one cycle later with sram_addr_valid=1.
REQ-019 SHALL hold all sram_* outputs stable while sram_addr_valid=1 and sram_ready=0; FSM moves to HOLD; no grant occurs.
REQ-020 SHALL select by round-robin priority pointer, reset to W0; after a grant to port k, the pointer becomes (k+1) mod 4.
REQ-021 SHALL keep a per-port wait counter: +1 each cycle a port is eligible but not granted; saturates at MAX_WAIT; clears on grant.
REQ-022 SHALL override round-robin when any counter equals MAX_WAIT: grant the lowest-index starved eligible port.
REQ-023 SHALL drive writes from wN_cmd fields; reads drive sram_addr=rN_addr, sram_write_mask=4'b0000, sram_data_in=0.
REQ-024 SHALL push a tag {valid=1, port} into a READ_LATENCY-deep shift register on each accepted read (sram_addr_valid & sram_ready); all other cycles push {valid=0}.
REQ-025 SHALL route data: when sram_data_out_valid=1 and the tag emerging from the shift register is valid, assert r0_data_wr or r1_data_wr by tag port, same cycle.
REQ-026 SHALL set tag_error on sram_data_out_valid with an invalid tag, or on a valid tag without sram_data_out_valid; in both cases no write enable is asserted.
REQ-027 SHALL go from ISSUE to IDLE when the command is accepted and nothing is granted; stay in ISSUE on back-to-back grants.

Reset
REQ-028 SHALL, on reset, clear req_pop, sram_addr_valid, sram_addr, sram_data_in, sram_write_mask, rN_data_wr and tag_error; FSM=IDLE; pointer=W0; counters=0; tags invalid.
REQ-029 SHALL, on reset mid-operation, discard presented and in-flight commands; for READ_LATENCY cycles after reset deasserts, drop untagged returned data without setting tag_error.

Verification
REQ-030 SHALL cover: req_valid=4'b1111, sram_ready=1, full=0 for 8 cycles -> grants W0,W1,R0,R1,W0,... one per cycle; commands on sram_* one cycle after each req_pop.
REQ-031 SHALL cover: R0 read addr 0x00ABC accepted at cycle t -> tag travels; sram_data_out_valid at t+3 -> r0_data_wr=1 at t+3, r1_data_wr=0.
REQ-032 SHALL cover: sram_ready=0 for 4 cycles with W1 command presented -> sram_* outputs unchanged, req_pop=0, FSM=HOLD; command accepted on the first cycle sram_ready=1.
REQ-033 SHALL cover: r1_full=1 with R1 valid, other ports idle -> no R1 grant, FSM stays IDLE; r1_full falls -> R1 granted next cycle.
REQ-034 SHALL cover: W0 and W1 continuously valid, R0 valid with the pointer forced past it -> R0 wait counter reaches 15 and R0 is granted no later than the following cycle.
REQ-035 SHALL cover: sram_data_out_valid pulse with no outstanding read -> tag_error=1 and stays 1 until reset; no rN_data_wr asserted.
